// File: rtl/tw_addr_sched_pkg.sv
// Shared types and helpers for the per-stage twiddle address scheduler.
// Optional build macro used by the scheduler files: TW_SCHED_PERF_EN.
package tw_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

  localparam int TW_LOGN_DEF = 3;
  localparam int FRAME_LEN   = 1 << TW_LOGN_DEF;
  localparam int ADDR_MAXW   = 16;

  // ROM address is the top `stage` bits of the in-frame sample counter
  function automatic logic [ADDR_MAXW-1:0] stage_addr(input logic [ADDR_MAXW-1:0] cnt,
                                                      input int logn,
                                                      input int stage);
    return cnt >> (logn - stage);
  endfunction

endpackage

// File: rtl/tw_addr_sched_if.sv
// Handshake/bus bundle between an MDC stage controller and tw_addr_sched.
// With TW_SCHED_PERF_EN defined the bundle also carries stall_cnt.
interface tw_addr_sched_if #(
  parameter int LOGN   = 3,
  parameter int FRAMEW = 8
);
  logic              start;
  logic [FRAMEW-1:0] nframes;
  logic              in_valid;
  logic [LOGN-1:0]   raddr;
  logic              tw_valid;
  logic              busy;
  logic              frame_last;
  logic              done;
  logic              err_drop;
`ifdef TW_SCHED_PERF_EN
  logic [15:0]       stall_cnt;

  modport master (output start, nframes, in_valid,
                  input  raddr, tw_valid, busy, frame_last, done, err_drop, stall_cnt);
  modport slave  (input  start, nframes, in_valid,
                  output raddr, tw_valid, busy, frame_last, done, err_drop, stall_cnt);
`else
  modport master (output start, nframes, in_valid,
                  input  raddr, tw_valid, busy, frame_last, done, err_drop);
  modport slave  (input  start, nframes, in_valid,
                  output raddr, tw_valid, busy, frame_last, done, err_drop);
`endif
endinterface

// File: rtl/tw_addr_sched_valid_dly.sv
// Fixed-depth valid delay line aligning tw_valid with the registered ROM output.
module tw_valid_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o
);

  logic [DEPTH-1:0] sr_q;

  // shift issued-sample flags toward the output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], din_i};
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/tw_addr_sched.sv
// Twiddle ROM address scheduler for one MDC NTT stage: frame counting, address issue, drain/done.
// Build macro TW_SCHED_PERF_EN adds a saturating stall counter on the bus.
module tw_addr_sched
  import tw_sched_pkg::*;
#(
  parameter int LOGN      = 3,
  parameter int STAGE     = 1,
  parameter int ROM_DELAY = 1,
  parameter int FRAMEW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  tw_addr_sched_if.slave bus
);

  localparam int             DCW       = $clog2(ROM_DELAY + 2);
  localparam logic [DCW-1:0] DRAIN_END = DCW'(ROM_DELAY + 1);

  tw_state_e         state_q;
  logic [LOGN-1:0]   cnt_q;
  logic [FRAMEW-1:0] frm_q;
  logic [DCW-1:0]    dcnt_q;
  logic [LOGN-1:0]   raddr_q;
  logic [LOGN-1:0]   raddr_d;
  logic              frame_last_q;
  logic              done_q;
  logic              err_drop_q;
  logic              issue_s;

  assign issue_s = (state_q == RUN) && bus.in_valid;
  assign raddr_d = LOGN'(stage_addr(ADDR_MAXW'(cnt_q), LOGN, STAGE));

  // control FSM with registered address, frame_last, done and err_drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      frm_q        <= '0;
      dcnt_q       <= '0;
      raddr_q      <= '0;
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      frame_last_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            frm_q      <= (bus.nframes == '0) ? '0 : bus.nframes - FRAMEW'(1);
            err_drop_q <= 1'b0;
          end else if (bus.in_valid) begin
            err_drop_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.in_valid) begin
            raddr_q <= raddr_d;
            cnt_q   <= cnt_q + LOGN'(1);
            if (cnt_q == '1) begin
              frame_last_q <= 1'b1;
              if (frm_q == '0) begin
                state_q <= DRAIN;
                dcnt_q  <= '0;
              end else begin
                frm_q <= frm_q - FRAMEW'(1);
              end
            end
          end
        end
        DRAIN: begin
          // wait until every issued sample has left the delay line
          if (dcnt_q == DRAIN_END) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            dcnt_q <= dcnt_q + DCW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  tw_valid_dly #(
    .DEPTH (ROM_DELAY + 1)
  ) u_valid_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (issue_s),
    .dout_o (bus.tw_valid)
  );

  assign bus.raddr      = raddr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_last = frame_last_q;
  assign bus.done       = done_q;
  assign bus.err_drop   = err_drop_q;

`ifdef TW_SCHED_PERF_EN
  logic [15:0] stall_cnt_q;

  // count RUN cycles without a sample, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q == IDLE) && bus.start) begin
      stall_cnt_q <= 16'h0000;
    end else if ((state_q == RUN) && !bus.in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tw_addr_sched.sv
// Bench for tw_addr_sched: three configurations (STAGE/ROM_DELAY = 2/1, 1/2, 3/1) share one stimulus;
// expected samples are queued when driven and popped when tw_valid appears.
module tb_tw_addr_sched;

  logic       clk;
  logic       rst_n;
  logic       start_r;
  logic       in_valid_r;
  logic [7:0] nframes_r;

  logic [2:0] raddr_a    [3];
  logic       tw_valid_a [3];
  logic       busy_a     [3];
  logic       fl_a       [3];
  logic       done_a     [3];
  logic       err_a      [3];
`ifdef TW_SCHED_PERF_EN
  logic [15:0] stall_a   [3];
`endif

  typedef struct {
    int addr;
    int cyc;
  } sb_t;

  sb_t        sbq [3][$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_state [3];
  int         m_cnt   [3];
  int         m_frm   [3];
  int         m_raddr [3];
  int         m_err   [3];
  int         m_fl    [3];
  int         m_done  [3];
  logic [2:0] raddr_h [3][16];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tw_addr_sched_if #(.LOGN(3), .FRAMEW(8)) bus_if ();

    assign bus_if.start    = start_r;
    assign bus_if.nframes  = nframes_r;
    assign bus_if.in_valid = in_valid_r;
    assign raddr_a[g]      = bus_if.raddr;
    assign tw_valid_a[g]   = bus_if.tw_valid;
    assign busy_a[g]       = bus_if.busy;
    assign fl_a[g]         = bus_if.frame_last;
    assign done_a[g]       = bus_if.done;
    assign err_a[g]        = bus_if.err_drop;
`ifdef TW_SCHED_PERF_EN
    assign stall_a[g]      = bus_if.stall_cnt;
`endif

    tw_addr_sched #(
      .LOGN      (3),
      .STAGE     ((g == 0) ? 2 : ((g == 1) ? 1 : 3)),
      .ROM_DELAY ((g == 1) ? 2 : 1),
      .FRAMEW    (8)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stg(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int rdl(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] cyc=%0d observed=%0d expected=%0d", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = 0;
      m_cnt[k]   = 0;
      m_frm[k]   = 0;
      m_raddr[k] = 0;
      m_err[k]   = 0;
      m_fl[k]    = -1;
      m_done[k]  = -1;
      sbq[k].delete();
    end
  endtask

  // e is the number of the clock edge that will sample the inputs being driven now
  task automatic model_drive(input logic st, input logic iv, input int e);
    int a;
    for (int k = 0; k < 3; k++) begin
      case (m_state[k])
        0: begin
          if (st) begin
            m_state[k] = 1;
            m_cnt[k]   = 0;
            m_frm[k]   = (nframes_r == 8'd0) ? 0 : int'(nframes_r) - 1;
            m_err[k]   = 0;
          end else if (iv) begin
            m_err[k] = 1;
          end
        end
        1: begin
          if (iv) begin
            a = m_cnt[k] >> (3 - stg(k));
            sbq[k].push_back('{addr: a, cyc: e + rdl(k)});
            m_raddr[k] = a;
            if (m_cnt[k] == 7) begin
              m_fl[k] = e;
              if (m_frm[k] == 0) begin
                m_state[k] = 2;
                m_done[k]  = e + rdl(k) + 2;
              end else begin
                m_frm[k] = m_frm[k] - 1;
              end
            end
            m_cnt[k] = (m_cnt[k] + 1) % 8;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic monitor();
    sb_t e;
    for (int k = 0; k < 3; k++) begin
      raddr_h[k][cyc % 16] = raddr_a[k];
      if ((m_state[k] == 2) && (cyc == m_done[k])) m_state[k] = 0;
      check("raddr", k, raddr_a[k], m_raddr[k]);
      check("busy", k, busy_a[k], m_state[k] != 0);
      check("frame_last", k, fl_a[k], cyc == m_fl[k]);
      check("done", k, done_a[k], cyc == m_done[k]);
      check("err_drop", k, err_a[k], m_err[k]);
      if (tw_valid_a[k]) begin
        if (sbq[k].size() == 0) begin
          check("tw_spurious", k, tw_valid_a[k], 1'b0);
        end else begin
          e = sbq[k].pop_front();
          check("tw_cycle", k, cyc, e.cyc);
          check("tw_addr", k, raddr_h[k][(cyc - rdl(k)) % 16], e.addr);
        end
      end else if ((sbq[k].size() != 0) && (sbq[k][0].cyc <= cyc)) begin
        check("tw_missing", k, tw_valid_a[k], 1'b1);
        void'(sbq[k].pop_front());
      end
    end
  endtask

  task automatic step(input logic st, input logic iv);
    start_r    = st;
    in_valid_r = iv;
    if (rst_n) model_drive(st, iv, cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start_r    = 1'b0;
    in_valid_r = 1'b0;
    nframes_r  = 8'd0;
    model_reset();
    #3;
    monitor();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // one frame, continuous samples
    nframes_r = 8'd1;
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);
    idle(6);

    // three frames back to back
    nframes_r = 8'd3;
    step(1'b1, 1'b0);
    repeat (24) step(1'b0, 1'b1);
    idle(6);

    // samples on alternate cycles
    nframes_r = 8'd1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, (i % 2) == 0);
    idle(6);
`ifdef TW_SCHED_PERF_EN
    for (int k = 0; k < 3; k++) check("stall_cnt", k, stall_a[k], 16'd7);
`endif

    // drop in IDLE, start with simultaneous sample, start during RUN
    step(1'b0, 1'b1);
    idle(3);
    nframes_r = 8'd2;
    step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(i == 5, 1'b1);
    idle(6);

    // asynchronous reset in the middle of a frame
    nframes_r = 8'd1;
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    monitor();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    idle(2);
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);
    idle(6);

    // nframes of zero runs one frame; samples during DRAIN are ignored
    nframes_r = 8'd0;
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(6);

    for (int k = 0; k < 3; k++) check("sb_empty", k, sbq[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
